restoring_divider_4bit: RTL and testbench

RESTORING_DIVIDER_4BIT -- requirements
Module: restoring_divider_4bit

---
 rtl/restoring_divider_pkg.sv | 15 +
 rtl/restoring_divider_4bit_sub.sv | 24 ++
 rtl/restoring_divider_4bit.sv | 113 +++++++++++
 tb/tb_restoring_divider_4bit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared types and sizing for the 4-bit restoring divider.
// Optional feature macro: DIV_ZERO_DETECT_EN.
package restoring_divider_pkg;

    localparam int WIDTH = 4;
    localparam int ITER  = 4;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_divider_4bit_sub.sv
// Ripple-borrow parallel subtractor: diff = a - b - borrow_in.
// Used as the only subtraction datapath of the divider.
module parallel_subtractor_4bit
    import restoring_divider_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic [WIDTH:0] bw;

    assign bw[0] = borrow_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign borrow_out = bw[WIDTH];

endmodule

// File: rtl/restoring_divider_4bit.sv
// Multi-cycle 4-bit unsigned restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_DETECT_EN to short-circuit D==0 straight to DONE.
module restoring_divider_4bit
    import restoring_divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] q_sr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prem_next;
    logic             borrow;
    logic             q_bit;
    logic             last_iter;
    logic             zero_div;

`ifdef DIV_ZERO_DETECT_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // prem < 2**i before iteration i, so prem[3] is never lost by the shift
    assign trial     = {prem[WIDTH-2:0], a_sr[WIDTH-1]};
    assign q_bit     = ~borrow;
    assign prem_next = borrow ? trial : diff;
    assign last_iter = (count == CNT_W'(ITER - 1));

    parallel_subtractor_4bit u_sub (
        .a          (trial),
        .b          (d_reg),
        .borrow_in  (1'b0),
        .diff       (diff),
        .borrow_out (borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = zero_div ? DONE : CALC;
            CALC:    if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr        <= '0;
            d_reg       <= '0;
            prem        <= '0;
            q_sr        <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= dividend;
                        d_reg <= divisor;
                        prem  <= '0;
                        q_sr  <= '0;
                        count <= '0;
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    a_sr  <= {a_sr[WIDTH-2:0], 1'b0};
                    prem  <= prem_next;
                    q_sr  <= {q_sr[WIDTH-2:0], q_bit};
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient    <= {q_sr[WIDTH-2:0], q_bit};
                        remainder   <= prem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Scoreboard bench for restoring_divider_4bit (honours DIV_ZERO_DETECT_EN).
module tb_restoring_divider_4bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0] a;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
        int         bcnt;
    } exp_t;

    exp_t sb[$];

    restoring_divider_4bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        if (d == 4'd0) begin
            e.q = 4'hF;
            e.r = a;
`ifdef DIV_ZERO_DETECT_EN
            e.dbz  = 1'b1;
            e.lat  = 0;
            e.bcnt = 0;
`else
            e.dbz  = 1'b0;
            e.lat  = 4;
            e.bcnt = 4;
`endif
        end else begin
            e.q    = a / d;
            e.r    = a % d;
            e.dbz  = 1'b0;
            e.lat  = 4;
            e.bcnt = 4;
        end
        return e;
    endfunction

    // lat counts edges after the accepting edge until done is seen
    task automatic run_div(input logic [3:0] a, input logic [3:0] d,
                           input bit poke);
        exp_t e;
        int   lat;
        int   bcnt;
        sb.push_back(model(a, d));
        @(negedge clk);
        dividend = a;
        divisor  = d;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            if (poke && lat < 2) begin
                start    = 1'b1;
                dividend = 4'd2;
                divisor  = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (!done && busy) bcnt++;
        end
        start = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL timeout %0d/%0d: done=%b after %0d edges",
                     e.a, e.d, done, lat);
        end
        n_vec++;
        if (lat !== e.lat) begin
            n_err++;
            $display("FAIL latency %0d/%0d: got %0d want %0d",
                     e.a, e.d, lat, e.lat);
        end
        n_vec++;
        if (bcnt !== e.bcnt) begin
            n_err++;
            $display("FAIL busy_cycles %0d/%0d: got %0d want %0d",
                     e.a, e.d, bcnt, e.bcnt);
        end
        n_vec++;
        if (quotient !== e.q) begin
            n_err++;
            $display("FAIL quotient %0d/%0d: got %0d want %0d",
                     e.a, e.d, quotient, e.q);
        end
        n_vec++;
        if (remainder !== e.r) begin
            n_err++;
            $display("FAIL remainder %0d/%0d: got %0d want %0d",
                     e.a, e.d, remainder, e.r);
        end
        n_vec++;
        if (div_by_zero !== e.dbz) begin
            n_err++;
            $display("FAIL div_by_zero %0d/%0d: got %b want %b",
                     e.a, e.d, div_by_zero, e.dbz);
        end
        if (e.d != 4'd0) begin
            n_vec++;
            if ((int'(quotient) * int'(e.d) + int'(remainder) != int'(e.a))
                || (remainder >= e.d)) begin
                n_err++;
                $display("FAIL invariant %0d/%0d: got q=%0d r=%0d",
                         e.a, e.d, quotient, remainder);
            end
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width %0d/%0d: done=%b want 0",
                     e.a, e.d, done);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_state: got b=%b d=%b q=%0d r=%0d z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_div(4'd13, 4'd3, 1'b0);
    endtask

    task automatic test_values();
        run_div(4'd15, 4'd1, 1'b0);
        run_div(4'd7,  4'd9, 1'b0);
        run_div(4'd0,  4'd5, 1'b0);
        run_div(4'd15, 4'd15, 1'b0);
    endtask

    task automatic test_div_zero();
        run_div(4'd10, 4'd0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_div(4'd13, 4'd3, 1'b1);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            n_err++;
            $display("FAIL abort_state: got b=%b d=%b q=%0d r=%0d z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_quiet: got done=%b busy=%b want 0/0",
                         done, busy);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        run_div(4'd9, 4'd2, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 16; a++) begin
            for (int d = 0; d < 16; d++) begin
                run_div(4'(a), 4'(d), 1'b0);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
